ttt_game_ctrl: RTL and testbench

Game sequencer for the tic-tac-toe datapath. It owns the board registers p1/p2 that feed the datapath, alternates turns and accepts or rejects moves. It reads the win/draw/invalid flags back from the datapath, pulses en1/en2 to advance the score counters, and drives restart and score-clear. The block sits between the player input logic and the datapath.

---
 rtl/ttt_game_ctrl_if.sv | 32 +++
 rtl/ttt_game_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_ttt_game_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ttt_game_ctrl_if.sv
// rtl/ttt_game_ctrl_if.sv - move/board/datapath signal bundle for the tic-tac-toe game sequencer
// master: player input logic plus datapath side; slave: ttt_game_ctrl.
interface ttt_game_ctrl_if;
    logic       move_valid;
    logic [3:0] move_idx;
    logic       new_round;
    logic       new_match;
    logic       win_in1;
    logic       win_in2;
    logic       draw_in;
    logic       inval_in;
    logic [0:8] p1;
    logic [0:8] p2;
    logic       en1;
    logic       en2;
    logic       restart;
    logic       score_clr;
    logic       turn;
    logic       move_err;

    modport master (
        output move_valid, move_idx, new_round, new_match,
        output win_in1, win_in2, draw_in, inval_in,
        input  p1, p2, en1, en2, restart, score_clr, turn, move_err
    );

    modport slave (
        input  move_valid, move_idx, new_round, new_match,
        input  win_in1, win_in2, draw_in, inval_in,
        output p1, p2, en1, en2, restart, score_clr, turn, move_err
    );
endinterface

// File: rtl/ttt_game_ctrl.sv
// rtl/ttt_game_ctrl.sv - tic-tac-toe game sequencer: board owner, turn/score/match control
// Optional MOVE_TIMEOUT_EN adds a per-turn forfeit counter of TIMEOUT_CYCLES cycles.
module ttt_game_ctrl #(
    parameter int WIN_TARGET = 3
`ifdef MOVE_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1000
`endif
) (
    input  logic           i_clk,
    input  logic           i_reset,
    ttt_game_ctrl_if.slave bus,
    output logic [2:0]     o_state,
    output logic [1:0]     o_match_winner
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_CLEAR      = 3'd1,
        S_PLAY       = 3'd2,
        S_CHECK      = 3'd3,
        S_R_WIN      = 3'd4,
        S_R_DRAW     = 3'd5,
        S_MATCH_OVER = 3'd6,
        S_FAULT      = 3'd7
    } state_t;

    localparam logic [1:0] W_TARGET = 2'(WIN_TARGET);

    state_t     r_state, w_next_state;
    logic [0:8] r_p1, r_p2, w_p1, w_p2;
    logic       r_turn, w_turn;
    logic       r_first, w_first;
    logic [1:0] r_sc1, r_sc2, w_sc1, w_sc2;
    logic [1:0] r_winner, w_winner;
    logic       r_en1, r_en2, r_restart, r_score_clr, r_move_err;
    logic       w_en1, w_en2, w_restart, w_score_clr, w_move_err;

    logic [0:8] w_cell;
    logic       w_accept;
    logic       w_fault;
    logic       w_target_hit;
    logic       w_expire;

    // One-hot cell decode; an index above 8 decodes to nothing and is rejected.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            w_cell[i] = (bus.move_idx == 4'(i));
        end
    end

    assign w_accept     = (r_state == S_PLAY) && bus.move_valid && (|w_cell)
                          && !(|(w_cell & (r_p1 | r_p2)));
    assign w_fault      = bus.inval_in || (bus.win_in1 && bus.win_in2);
    assign w_target_hit = (r_sc1 == W_TARGET) || (r_sc2 == W_TARGET);

`ifdef MOVE_TIMEOUT_EN
    localparam int            CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_to_cnt, w_to_cnt;

    assign w_expire = (r_state == S_PLAY) && !w_accept && !bus.new_match && (r_to_cnt == '0);
    // Held at the load value outside PLAY, so every PLAY entry starts a full turn.
    assign w_to_cnt = ((r_state != S_PLAY) || w_accept || w_expire) ? CNT_LOAD
                                                                   : r_to_cnt - CW'(1);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_to_cnt <= CNT_LOAD;
        end else begin
            r_to_cnt <= w_to_cnt;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_p1        <= '0;
            r_p2        <= '0;
            r_turn      <= 1'b0;
            r_first     <= 1'b0;
            r_sc1       <= 2'd0;
            r_sc2       <= 2'd0;
            r_winner    <= 2'b00;
            r_en1       <= 1'b0;
            r_en2       <= 1'b0;
            r_restart   <= 1'b0;
            r_score_clr <= 1'b0;
            r_move_err  <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_p1        <= w_p1;
            r_p2        <= w_p2;
            r_turn      <= w_turn;
            r_first     <= w_first;
            r_sc1       <= w_sc1;
            r_sc2       <= w_sc2;
            r_winner    <= w_winner;
            r_en1       <= w_en1;
            r_en2       <= w_en2;
            r_restart   <= w_restart;
            r_score_clr <= w_score_clr;
            r_move_err  <= w_move_err;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (bus.new_match) begin
            w_next_state = S_CLEAR;
        end else begin
            case (r_state)
                S_IDLE:  w_next_state = S_CLEAR;
                S_CLEAR: w_next_state = S_PLAY;
                S_PLAY: begin
                    if (w_accept) w_next_state = S_CHECK;
                end
                S_CHECK: begin
                    if (w_fault)                           w_next_state = S_FAULT;
                    else if (bus.win_in1 || bus.win_in2)   w_next_state = S_R_WIN;
                    else if (bus.draw_in)                  w_next_state = S_R_DRAW;
                    else                                   w_next_state = S_PLAY;
                end
                S_R_WIN, S_R_DRAW: begin
                    if (bus.new_round) w_next_state = w_target_hit ? S_MATCH_OVER : S_CLEAR;
                end
                default: w_next_state = r_state;
            endcase
        end
    end

    // Pulses are registered, so each one appears in the cycle after the deciding state.
    always_comb begin
        w_p1        = r_p1;
        w_p2        = r_p2;
        w_turn      = r_turn;
        w_first     = r_first;
        w_sc1       = r_sc1;
        w_sc2       = r_sc2;
        w_winner    = r_winner;
        w_en1       = 1'b0;
        w_en2       = 1'b0;
        w_restart   = 1'b0;
        w_score_clr = 1'b0;
        w_move_err  = 1'b0;
        if (bus.new_match) begin
            w_sc1       = 2'd0;
            w_sc2       = 2'd0;
            w_first     = 1'b0;
            w_winner    = 2'b00;
            w_score_clr = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: w_score_clr = 1'b1;
                S_CLEAR: begin
                    w_p1      = '0;
                    w_p2      = '0;
                    w_restart = 1'b1;
                    w_turn    = r_first;
                end
                S_PLAY: begin
                    if (w_accept) begin
                        if (r_turn) w_p2 = r_p2 | w_cell;
                        else        w_p1 = r_p1 | w_cell;
                    end else begin
                        w_move_err = bus.move_valid || w_expire;
                        if (w_expire) w_turn = ~r_turn;
                    end
                end
                S_CHECK: begin
                    if (!w_fault) begin
                        if (bus.win_in1) begin
                            w_en1 = 1'b1;
                            w_sc1 = r_sc1 + 2'd1;
                        end else if (bus.win_in2) begin
                            w_en2 = 1'b1;
                            w_sc2 = r_sc2 + 2'd1;
                        end else if (!bus.draw_in) begin
                            w_turn = ~r_turn;
                        end
                    end
                end
                S_R_WIN, S_R_DRAW: begin
                    if (bus.new_round) begin
                        if (w_target_hit) w_winner = (r_sc1 == W_TARGET) ? 2'b01 : 2'b10;
                        else              w_first  = ~r_first;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.p1         = r_p1;
    assign bus.p2         = r_p2;
    assign bus.en1        = r_en1;
    assign bus.en2        = r_en2;
    assign bus.restart    = r_restart;
    assign bus.score_clr  = r_score_clr;
    assign bus.turn       = r_turn;
    assign bus.move_err   = r_move_err;
    assign o_state        = r_state;
    assign o_match_winner = r_winner;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// tb/tb_ttt_game_ctrl.sv - randomized self-checking bench for ttt_game_ctrl against a game-rules model
module tb_ttt_game_ctrl;
    localparam int WT = 2;
`ifdef MOVE_TIMEOUT_EN
    localparam int TO = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] state;
    logic [1:0] mwin;

    ttt_game_ctrl_if bus ();

`ifdef MOVE_TIMEOUT_EN
    ttt_game_ctrl #(.WIN_TARGET(WT), .TIMEOUT_CYCLES(TO)) dut (
`else
    ttt_game_ctrl #(.WIN_TARGET(WT)) dut (
`endif
        .i_clk          (clk),
        .i_reset        (rst),
        .bus            (bus),
        .o_state        (state),
        .o_match_winner (mwin)
    );

    always #5 clk = ~clk;

    // Behavioural datapath: flags derived combinationally from the board the DUT drives.
    logic force_inval = 1'b0;
    logic force_both  = 1'b0;

    function automatic logic has_line(input logic [0:8] v);
        return (v[0] & v[1] & v[2]) | (v[3] & v[4] & v[5]) | (v[6] & v[7] & v[8])
             | (v[0] & v[3] & v[6]) | (v[1] & v[4] & v[7]) | (v[2] & v[5] & v[8])
             | (v[0] & v[4] & v[8]) | (v[2] & v[4] & v[6]);
    endfunction

    assign bus.win_in1  = force_both | has_line(bus.p1);
    assign bus.win_in2  = force_both | has_line(bus.p2);
    assign bus.draw_in  = &(bus.p1 | bus.p2);
    assign bus.inval_in = force_inval | (|(bus.p1 & bus.p2));

    // Reference model: board as cell owners, phase 0 play,1 won,2 draw,3 match over,4 fault.
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    int b [9];
    int m_turn, m_first, m_sc1, m_sc2, m_phase, m_winner;
    int rej_run;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_state();
        case (m_phase)
            0:       return 2;
            1:       return 4;
            2:       return 5;
            3:       return 6;
            default: return 7;
        endcase
    endfunction

    function automatic logic [0:8] mb(input int p);
        logic [0:8] v;
        for (int i = 0; i < 9; i++) v[i] = (b[i] == p);
        return v;
    endfunction

    function automatic bit model_won(input int p);
        for (int l = 0; l < 8; l++)
            if (b[lines[l][0]] == p && b[lines[l][1]] == p && b[lines[l][2]] == p) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_full();
        for (int i = 0; i < 9; i++) if (b[i] == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_board();
        for (int i = 0; i < 9; i++) b[i] = 0;
    endtask

    task automatic chk_all(input string t);
        check({t, ".p1"}, 32'(bus.p1), 32'(mb(1)));
        check({t, ".p2"}, 32'(bus.p2), 32'(mb(2)));
        check({t, ".turn"}, 32'(bus.turn), m_turn);
        check({t, ".state"}, 32'(state), exp_state());
        check({t, ".winner"}, 32'(mwin), m_winner);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        check("rst.state", 32'(state), 0);
        check("rst.p1", 32'(bus.p1), 0);
        check("rst.p2", 32'(bus.p2), 0);
        check("rst.turn", 32'(bus.turn), 0);
        check("rst.pulses", {bus.en1, bus.en2, bus.restart, bus.score_clr, bus.move_err}, 0);
        check("rst.winner", 32'(mwin), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rel.state", 32'(state), 1);
        check("rel.score_clr", 32'(bus.score_clr), 1);
        check("rel.restart", 32'(bus.restart), 0);
        @(negedge clk);
        clear_board();
        m_turn = 0; m_first = 0; m_sc1 = 0; m_sc2 = 0; m_phase = 0; m_winner = 0;
        check("rel2.restart", 32'(bus.restart), 1);
        check("rel2.score_clr", 32'(bus.score_clr), 0);
        chk_all("rel2");
    endtask

    task automatic do_move(input int idx);
        bit accept;
        int p;
        accept = (m_phase == 0) && (idx <= 8) && (b[idx] == 0);
        bus.move_valid = 1'b1;
        bus.move_idx   = 4'(idx);
        @(negedge clk);
        bus.move_valid = 1'b0;
        if (m_phase != 0) begin
            check("ign.err", 32'(bus.move_err), 0);
            chk_all("ign");
        end else if (!accept) begin
            check("rej.err", 32'(bus.move_err), 1);
            chk_all("rej");
        end else begin
            p = m_turn + 1;
            b[idx] = p;
            check("acc.err", 32'(bus.move_err), 0);
            check("acc.state", 32'(state), 3);
            check("acc.p1", 32'(bus.p1), 32'(mb(1)));
            check("acc.p2", 32'(bus.p2), 32'(mb(2)));
            check("acc.en", {bus.en1, bus.en2}, 0);
            @(negedge clk);
            if (force_inval || force_both) m_phase = 4;
            else if (model_won(p)) begin
                m_phase = 1;
                if (p == 1) m_sc1++; else m_sc2++;
            end else if (model_full()) m_phase = 2;
            else m_turn ^= 1;
            check("res.en1", 32'(bus.en1), (m_phase == 1 && p == 1) ? 1 : 0);
            check("res.en2", 32'(bus.en2), (m_phase == 1 && p == 2) ? 1 : 0);
            chk_all("res");
            if (m_phase != 0) begin
                @(negedge clk);
                check("post.en", {bus.en1, bus.en2}, 0);
                check("post.state", 32'(state), exp_state());
            end
        end
    endtask

    task automatic pulse_new_round();
        bus.new_round = 1'b1;
        @(negedge clk);
        bus.new_round = 1'b0;
        if (m_phase == 1 || m_phase == 2) begin
            if (m_sc1 == WT || m_sc2 == WT) begin
                m_phase  = 3;
                m_winner = (m_sc1 == WT) ? 1 : 2;
                chk_all("nr.over");
            end else begin
                m_first ^= 1;
                check("nr.state", 32'(state), 1);
                @(negedge clk);
                clear_board();
                m_turn  = m_first;
                m_phase = 0;
                check("nr.restart", 32'(bus.restart), 1);
                chk_all("nr.play");
            end
        end else begin
            check("nr.ign.state", 32'(state), exp_state());
        end
    endtask

    task automatic pulse_new_match();
        bus.new_match  = 1'b1;
        bus.new_round  = 1'($urandom_range(0, 1));
        bus.move_valid = 1'($urandom_range(0, 1));
        bus.move_idx   = 4'($urandom_range(0, 8));
        @(negedge clk);
        bus.new_match  = 1'b0;
        bus.new_round  = 1'b0;
        bus.move_valid = 1'b0;
        check("nm.state", 32'(state), 1);
        check("nm.score_clr", 32'(bus.score_clr), 1);
        check("nm.err", 32'(bus.move_err), 0);
        @(negedge clk);
        clear_board();
        m_turn = 0; m_first = 0; m_sc1 = 0; m_sc2 = 0; m_phase = 0; m_winner = 0;
        check("nm.restart", 32'(bus.restart), 1);
        check("nm.score_clr2", 32'(bus.score_clr), 0);
        chk_all("nm.play");
    endtask

    function automatic int pick();
        int r;
        int free_q[$];
        int occ_q[$];
        for (int i = 0; i < 9; i++) begin
            if (b[i] == 0) free_q.push_back(i);
            else           occ_q.push_back(i);
        end
        r = int'($urandom_range(0, 99));
        if (rej_run < 2 && r < 8) begin
            rej_run++;
            return int'($urandom_range(9, 15));
        end
        if (rej_run < 2 && r < 18 && occ_q.size() > 0) begin
            rej_run++;
            return occ_q[$urandom_range(0, occ_q.size() - 1)];
        end
        rej_run = 0;
        return free_q[$urandom_range(0, free_q.size() - 1)];
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        bus.move_valid = 1'b0;
        bus.move_idx   = 4'd0;
        bus.new_round  = 1'b0;
        bus.new_match  = 1'b0;
        rej_run        = 0;
        do_reset();

        // Top-row win by player 1, then rejected overlapping and out-of-range moves.
        do_move(0); do_move(3); do_move(1); do_move(4); do_move(2);
        pulse_new_match();
        do_move(4); do_move(4); do_move(9);

        // Two-round match to target 2; second round starts with player 2.
        pulse_new_match();
        do_move(0); do_move(3); do_move(1); do_move(4); do_move(2);
        pulse_new_round();
        do_move(6); do_move(0); do_move(7); do_move(1); do_move(5); do_move(2);
        pulse_new_round();
        do_move(3);
        pulse_new_round();
        pulse_new_match();

        // Datapath faults: overlap flag, then both win flags together.
        force_inval = 1'b1;
        do_move(0);
        force_inval = 1'b0;
        pulse_new_round();
        do_move(1);
        pulse_new_match();
        force_both = 1'b1;
        do_move(8);
        force_both = 1'b0;
        pulse_new_match();

        // Asynchronous reset mid-round.
        do_move(2);
        #2 rst = 1'b1;
        #1 check("arst.state", 32'(state), 0);
        check("arst.p1", 32'(bus.p1), 0);
        do_reset();

        for (int g = 0; g < 6; g++) begin
            guard = 0;
            while (m_phase != 3 && guard < 300) begin
                if (m_phase == 0) begin
                    if ($urandom_range(0, 149) == 0) pulse_new_match();
                    else do_move(pick());
                end else if (m_phase == 4) begin
                    pulse_new_match();
                end else begin
                    if ($urandom_range(0, 3) == 0) do_move(int'($urandom_range(0, 15)));
                    pulse_new_round();
                end
                guard++;
            end
            if (m_phase != 3) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rand.bound: got phase %0d expected 3", m_phase);
            end
            pulse_new_match();
        end

`ifdef MOVE_TIMEOUT_EN
        for (int k = 0; k < TO - 1; k++) begin
            @(negedge clk);
            check("to.wait.err", 32'(bus.move_err), 0);
        end
        @(negedge clk);
        m_turn = 1;
        check("to.err", 32'(bus.move_err), 1);
        chk_all("to");
        @(negedge clk);
        check("to.err2", 32'(bus.move_err), 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("to.rst.state", 32'(state), 0);
        do_reset();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
